// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the per-axis state type.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } axis_state_t;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Enable input and video timing outputs of the VGA timing controller.
interface vga_timing_ctrl_if;
    import vga_pkg::*;

    logic             i_en;
    logic             o_pix_tick;
    logic             o_pix_valid;
    logic [CNT_W-1:0] o_col;
    logic [CNT_W-1:0] o_row;
    logic             o_hsync;
    logic             o_vsync;
    logic             o_frame_start;

    modport master (
        input  i_en,
        output o_pix_tick, o_pix_valid, o_col, o_row, o_hsync, o_vsync, o_frame_start
    );

    modport slave (
        output i_en,
        input  o_pix_tick, o_pix_valid, o_col, o_row, o_hsync, o_vsync, o_frame_start
    );

endinterface

// File: rtl/vga_axis_fsm.sv
// One timing axis: a wrapping position counter and the region FSM that follows it.
//   state  | meaning
//   ACTIVE | count in visible region
//   FRONT  | front porch
//   SYNC   | sync pulse
//   BACK   | back porch, leaves on wrap to 0
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int VISIBLE   = H_VISIBLE,
    parameter int FRONT_LEN = H_FRONT,
    parameter int SYNC_LEN  = H_SYNC,
    parameter int BACK_LEN  = H_BACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output axis_state_t      state,
    output logic             wrap
);

    localparam int TOTAL = VISIBLE + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_FIRST = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_FIRST  = CNT_W'(VISIBLE + FRONT_LEN);
    localparam logic [CNT_W-1:0] BACK_FIRST  = CNT_W'(VISIBLE + FRONT_LEN + SYNC_LEN);

    logic [CNT_W-1:0] count_nxt;
    axis_state_t      state_nxt;

    assign wrap = advance && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            state <= ACTIVE;
        end else begin
            count <= count_nxt;
            state <= state_nxt;
        end
    end

    // State changes on the same advance that moves the count onto a region's first value.
    always_comb begin
        count_nxt = count;
        state_nxt = state;
        if (advance) begin
            count_nxt = wrap ? '0 : count + CNT_W'(1);
            case (state)
                ACTIVE:  if (count_nxt == FRONT_FIRST) state_nxt = FRONT;
                FRONT:   if (count_nxt == SYNC_FIRST)  state_nxt = SYNC;
                SYNC:    if (count_nxt == BACK_FIRST)  state_nxt = BACK;
                BACK:    if (wrap)                     state_nxt = ACTIVE;
                default: state_nxt = ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: system-clock divider producing pixel ticks that step
// a horizontal and a vertical axis FSM.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = H_VISIBLE,
    parameter int H_FP    = H_FRONT,
    parameter int H_SY    = H_SYNC,
    parameter int H_BP    = H_BACK,
    parameter int V_VIS   = V_VISIBLE,
    parameter int V_FP    = V_FRONT,
    parameter int V_SY    = V_SYNC,
    parameter int V_BP    = V_BACK
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_ctrl_if.master vga
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]       div;
    logic             pix_tick;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_advance;
    logic             frame_start;
    logic             pix_valid;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    axis_state_t      h_state;
    axis_state_t      v_state;

    // Gated by rst so CLK_DIV=1 cannot tick while held in reset.
    assign pix_tick = vga.i_en && !rst && (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (vga.i_en) begin
            div <= pix_tick ? '0 : div + 4'd1;
        end
    end

    vga_axis_fsm #(
        .VISIBLE   (H_VIS),
        .FRONT_LEN (H_FP),
        .SYNC_LEN  (H_SY),
        .BACK_LEN  (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .advance (pix_tick),
        .count   (h_count),
        .state   (h_state),
        .wrap    (h_wrap)
    );

    assign v_advance = pix_tick && h_wrap;

    vga_axis_fsm #(
        .VISIBLE   (V_VIS),
        .FRONT_LEN (V_FP),
        .SYNC_LEN  (V_SY),
        .BACK_LEN  (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .advance (v_advance),
        .count   (v_count),
        .state   (v_state),
        .wrap    (v_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_advance && v_wrap;
        end
    end

    // Outputs decode the axis flops directly, so they move on the same tick as the counters.
    assign pix_valid         = (h_state == ACTIVE) && (v_state == ACTIVE);
    assign vga.o_pix_tick    = pix_tick;
    assign vga.o_pix_valid   = pix_valid;
    assign vga.o_col         = pix_valid ? h_count : '0;
    assign vga.o_row         = pix_valid ? v_count : '0;
    assign vga.o_hsync       = (h_state != SYNC);
    assign vga.o_vsync       = (v_state != SYNC);
    assign vga.o_frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-size instance at CLK_DIV=4 and a reduced-geometry
// instance at CLK_DIV=1, both checked every clk against a pixel-index reference model.
module tb_vga_timing_ctrl;

    localparam int CD_M = 4;
    localparam int CD_S = 1;
    localparam int HT_M = 800;
    localparam int VT_M = 525;
    localparam int HT_S = 30;
    localparam int VT_S = 14;
    localparam logic [24:0] RST_VEC = {1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0};

    logic clk   = 1'b0;
    logic rst_m = 1'b0;
    logic rst_s = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    vga_timing_ctrl_if ifm ();
    vga_timing_ctrl_if ifs ();

    vga_timing_ctrl #(.CLK_DIV(CD_M)) dut_m (
        .clk (clk),
        .rst (rst_m),
        .vga (ifm)
    );

    vga_timing_ctrl #(
        .CLK_DIV (CD_S),
        .H_VIS (20), .H_FP (2), .H_SY (3), .H_BP (5),
        .V_VIS (8),  .V_FP (1), .V_SY (2), .V_BP (3)
    ) dut_s (
        .clk (clk),
        .rst (rst_s),
        .vga (ifs)
    );

    always #5 clk = ~clk;

    // Reference: a divider phase plus a linear pixel index over the whole frame.
    int mm_div, mm_pix, ms_div, ms_pix;
    bit mm_fs, ms_fs;

    always @(posedge clk or posedge rst_m) begin
        if (rst_m) begin
            mm_div = 0; mm_pix = 0; mm_fs = 0;
        end else begin
            mm_fs = 0;
            if (ifm.i_en) begin
                if (mm_div == CD_M - 1) begin
                    mm_div = 0;
                    mm_pix = (mm_pix + 1) % (HT_M * VT_M);
                    mm_fs  = (mm_pix == 0);
                end else begin
                    mm_div = mm_div + 1;
                end
            end
        end
    end

    always @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            ms_div = 0; ms_pix = 0; ms_fs = 0;
        end else begin
            ms_fs = 0;
            if (ifs.i_en) begin
                if (ms_div == CD_S - 1) begin
                    ms_div = 0;
                    ms_pix = (ms_pix + 1) % (HT_S * VT_S);
                    ms_fs  = (ms_pix == 0);
                end else begin
                    ms_div = ms_div + 1;
                end
            end
        end
    end

    function automatic logic [24:0] model_out(int pix, bit tick, bit fs, int hv, int hf, int hs,
                                              int hb, int vv, int vf, int vs);
        int ht = hv + hf + hs + hb;
        int h  = pix % ht;
        int v  = pix / ht;
        bit valid = (h < hv) && (v < vv);
        logic [9:0] col = valid ? 10'(h) : 10'd0;
        logic [9:0] row = valid ? 10'(v) : 10'd0;
        bit hs_n = !((h >= hv + hf) && (h < hv + hf + hs));
        bit vs_n = !((v >= vv + vf) && (v < vv + vf + vs));
        return {tick, valid, col, row, hs_n, vs_n, fs};
    endfunction

    function automatic logic [24:0] exp_m();
        return model_out(mm_pix, ifm.i_en && !rst_m && (mm_div == CD_M - 1), mm_fs,
                         640, 16, 96, 48, 480, 10, 2);
    endfunction

    function automatic logic [24:0] exp_s();
        return model_out(ms_pix, ifs.i_en && !rst_s && (ms_div == CD_S - 1), ms_fs,
                         20, 2, 3, 5, 8, 1, 2);
    endfunction

    function automatic logic [24:0] obs_m();
        return {ifm.o_pix_tick, ifm.o_pix_valid, ifm.o_col, ifm.o_row,
                ifm.o_hsync, ifm.o_vsync, ifm.o_frame_start};
    endfunction

    function automatic logic [24:0] obs_s();
        return {ifs.o_pix_tick, ifs.o_pix_valid, ifs.o_col, ifs.o_row,
                ifs.o_hsync, ifs.o_vsync, ifs.o_frame_start};
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_m() !== RST_VEC) begin
                n_fail++;
                $display("FAIL reset_m: got %h expected %h", obs_m(), RST_VEC);
            end
            n_checks++;
            if (obs_s() !== RST_VEC) begin
                n_fail++;
                $display("FAIL reset_s: got %h expected %h", obs_s(), RST_VEC);
            end
        end
        rst_m = 1'b0;
        rst_s = 1'b0;
    endtask

    task automatic test_line_timing();
        int   last_tick = -1;
        int   last_fall = -1;
        int   low_ticks = 0;
        bit   saw_fall  = 0;
        logic prev_hs   = 1'b1;
        for (int c = 0; c < 7000; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_m() !== exp_m()) begin
                n_fail++;
                $display("FAIL line_m @%0d: got %h expected %h", c, obs_m(), exp_m());
            end
            if (ifm.o_pix_tick) begin
                if (last_tick >= 0) begin
                    n_checks++;
                    if (c - last_tick != 4) begin
                        n_fail++;
                        $display("FAIL tick_period: got %0d expected 4", c - last_tick);
                    end
                end
                last_tick = c;
                if (!ifm.o_hsync) low_ticks++;
            end
            if (prev_hs && !ifm.o_hsync) begin
                if (last_fall >= 0) begin
                    n_checks++;
                    if (c - last_fall != 3200) begin
                        n_fail++;
                        $display("FAIL line_clks: got %0d expected 3200", c - last_fall);
                    end
                end
                last_fall = c;
                saw_fall  = 1;
            end
            if (!prev_hs && ifm.o_hsync) begin
                if (saw_fall) begin
                    n_checks++;
                    if (low_ticks != 96) begin
                        n_fail++;
                        $display("FAIL hsync_ticks: got %0d expected 96", low_ticks);
                    end
                end
                low_ticks = 0;
            end
            prev_hs = ifm.o_hsync;
        end
    endtask

    task automatic test_enable_drop();
        int   ticks    = 0;
        bit   counting = 0;
        bit   dropped  = 0;
        bit   done     = 0;
        logic prev_hs;
        prev_hs = ifm.o_hsync;
        for (int c = 0; c < 12000 && !done; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_m() !== exp_m()) begin
                n_fail++;
                $display("FAIL en_run_m @%0d: got %h expected %h", c, obs_m(), exp_m());
            end
            if (prev_hs && !ifm.o_hsync) begin
                if (counting) begin
                    n_checks++;
                    if (ticks != 800) begin
                        n_fail++;
                        $display("FAIL line_ticks_after_drop: got %0d expected 800", ticks);
                    end
                    done = 1;
                end else begin
                    counting = 1;
                end
            end
            if (counting && !done && ifm.o_pix_tick) ticks++;
            if (counting && !dropped && (mm_pix % HT_M == 700)) begin
                dropped   = 1;
                ifm.i_en  = 1'b0;
                for (int k = 0; k < 37; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (obs_m() !== exp_m() || ifm.o_pix_tick !== 1'b0) begin
                        n_fail++;
                        $display("FAIL en_hold @%0d: got %h expected %h", k, obs_m(), exp_m());
                    end
                end
                ifm.i_en = 1'b1;
            end
            prev_hs = ifm.o_hsync;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL en_drop_timeout: got done=%0d expected 1", done);
        end
    endtask

    task automatic test_async_reset();
        bit found     = 0;
        int first_col = -1;
        for (int c = 0; c < 4000 && !found; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_m() !== exp_m()) begin
                n_fail++;
                $display("FAIL pre_rst_m @%0d: got %h expected %h", c, obs_m(), exp_m());
            end
            if (mm_pix % HT_M == 300) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL rst_point_timeout: got found=%0d expected 1", found);
        end
        #2 rst_m = 1'b1;
        #1;
        n_checks++;
        if (obs_m() !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_rst: got %h expected %h", obs_m(), RST_VEC);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (obs_m() !== RST_VEC) begin
            n_fail++;
            $display("FAIL rst_hold: got %h expected %h", obs_m(), RST_VEC);
        end
        rst_m = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_m() !== exp_m() || ifm.o_frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL post_rst_m @%0d: got %h expected %h", c, obs_m(), exp_m());
            end
            if (first_col < 0 && ifm.o_col != 10'd0) first_col = int'(ifm.o_col);
        end
        n_checks++;
        if (first_col != 1) begin
            n_fail++;
            $display("FAIL first_tick_col: got %0d expected 1", first_col);
        end
    endtask

    task automatic test_random_enable();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_m() !== exp_m()) begin
                n_fail++;
                $display("FAIL rand_m @%0d: got %h expected %h", c, obs_m(), exp_m());
            end
            n_checks++;
            if (obs_s() !== exp_s()) begin
                n_fail++;
                $display("FAIL rand_s @%0d: got %h expected %h", c, obs_s(), exp_s());
            end
            ifm.i_en = ($urandom_range(0, 3) != 0);
            ifs.i_en = ($urandom_range(0, 3) != 0);
        end
        ifm.i_en = 1'b1;
        ifs.i_en = 1'b1;
    endtask

    task automatic test_small_frames();
        int        ticks = 0, vs_low = 0, valid_n = 0, fs_n = 0;
        bit [19:0] col_seen = '0;
        bit [7:0]  row_seen = '0;
        @(negedge clk);
        rst_s = 1'b1;
        #1;
        n_checks++;
        if (obs_s() !== RST_VEC) begin
            n_fail++;
            $display("FAIL rst_s_div1: got %h expected %h", obs_s(), RST_VEC);
        end
        @(posedge clk);
        @(negedge clk);
        rst_s = 1'b0;
        for (int c = 0; c < 2 * HT_S * VT_S; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_s() !== exp_s()) begin
                n_fail++;
                $display("FAIL frame_s @%0d: got %h expected %h", c, obs_s(), exp_s());
            end
            if (ifs.o_pix_tick) ticks++;
            if (!ifs.o_vsync) vs_low++;
            if (ifs.o_pix_valid) begin
                valid_n++;
                if (ifs.o_col < 10'd20) col_seen[ifs.o_col[4:0]] = 1'b1;
                if (ifs.o_row < 10'd8)  row_seen[ifs.o_row[2:0]] = 1'b1;
            end
            if (ifs.o_frame_start) begin
                fs_n++;
                n_checks++;
                if (ifs.o_pix_valid !== 1'b1 || ifs.o_col !== 10'd0 || ifs.o_row !== 10'd0) begin
                    n_fail++;
                    $display("FAIL wrap_valid: got valid=%b col=%0d row=%0d expected 1 0 0",
                             ifs.o_pix_valid, ifs.o_col, ifs.o_row);
                end
            end
        end
        n_checks++;
        if (ticks != 2 * HT_S * VT_S) begin
            n_fail++;
            $display("FAIL tick_const: got %0d expected %0d", ticks, 2 * HT_S * VT_S);
        end
        n_checks++;
        if (vs_low != 2 * 2 * HT_S) begin
            n_fail++;
            $display("FAIL vsync_ticks: got %0d expected %0d", vs_low, 2 * 2 * HT_S);
        end
        n_checks++;
        if (valid_n != 2 * 20 * 8) begin
            n_fail++;
            $display("FAIL valid_ticks: got %0d expected %0d", valid_n, 2 * 20 * 8);
        end
        n_checks++;
        if (fs_n != 2) begin
            n_fail++;
            $display("FAIL frame_starts: got %0d expected 2", fs_n);
        end
        n_checks++;
        if (col_seen !== {20{1'b1}} || row_seen !== {8{1'b1}}) begin
            n_fail++;
            $display("FAIL coverage: got col=%h row=%h expected fffff ff", col_seen, row_seen);
        end
    endtask

    initial begin
        ifm.i_en = 1'b1;
        ifs.i_en = 1'b1;
        #1;
        rst_m = 1'b1;
        rst_s = 1'b1;
        test_reset();
        test_line_timing();
        test_enable_drop();
        test_async_reset();
        test_random_enable();
        test_small_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
